// File: rtl/rr_stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package rr_stream_arb_pkg;

  // ARB: free round-robin pick each beat; LOCK: grant pinned to a packet in flight.
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Mod-n increment with an explicit wrap, so non-power-of-2 n works.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    int unsigned nxt;
    nxt = ptr + 1;
    if (nxt >= n) begin
      nxt = 0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pipeline_reg.sv
// Full-throughput valid/ready register stage: accepts a new beat whenever it is
// empty or its current beat is being drained in the same cycle.
module pipeline_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [Width-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [Width-1:0] o_data
);

  logic             r_valid;
  logic [Width-1:0] r_data;
  logic             w_load;

  assign o_ready = !r_valid || i_ready;
  assign w_load  = i_valid && o_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Load on accept, clear when drained with nothing new, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter merging N valid/ready streams onto one registered output,
// keeping multi-beat packets atomic and tagging each beat with its source index.
module rr_stream_arbiter
  import rr_stream_arb_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SRC_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*W-1:0]     in_data,
  input  logic [N-1:0]       in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic               out_last,
  output logic [SRC_W-1:0]   out_src
);

  localparam int unsigned PayloadW = W + 1 + SRC_W;

  arb_state_e           r_state;
  logic [SRC_W-1:0]     r_rr_ptr;
  logic [SRC_W-1:0]     r_lock_src;

  logic                 w_has_grant;
  logic [SRC_W-1:0]     w_grant;
  logic                 w_can_load;
  logic                 w_accept;
  logic [W-1:0]         w_sel_data;
  logic                 w_sel_last;
  logic [PayloadW-1:0]  w_payload_in;
  logic [PayloadW-1:0]  w_payload_out;
  logic [SRC_W:0]       w_pick;

  // First valid index at or after ptr, circularly; MSB flags whether one exists.
  function automatic logic [SRC_W:0] rr_pick(input logic [N-1:0]     valid,
                                             input logic [SRC_W-1:0] ptr);
    logic             found;
    logic [SRC_W-1:0] idx;
    logic [SRC_W-1:0] j_idx;
    int unsigned      j;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      j = 32'(ptr) + off;
      if (j >= N) begin
        j = j - N;
      end
      j_idx = SRC_W'(j);
      if (!found && valid[j_idx]) begin
        found = 1'b1;
        idx   = j_idx;
      end
    end
    return {found, idx};
  endfunction

  assign w_pick = rr_pick(in_valid, r_rr_ptr);

  // Grant selection: round-robin in ARB, pinned to the packet owner in LOCK.
  always_comb begin
    w_has_grant = 1'b0;
    w_grant     = '0;
    if (r_state == LOCK) begin
      w_has_grant = 1'b1;
      w_grant     = r_lock_src;
    end else begin
      w_has_grant = w_pick[SRC_W];
      w_grant     = w_pick[SRC_W-1:0];
    end
  end

  // Only the granted requester sees ready; ready is forced low during reset.
  always_comb begin
    in_ready = '0;
    if (w_has_grant && rst_n) begin
      in_ready[w_grant] = w_can_load;
    end
  end

  assign w_sel_data   = in_data[w_grant*W +: W];
  assign w_sel_last   = in_last[w_grant];
  assign w_accept     = w_has_grant && in_valid[w_grant] && w_can_load && rst_n;
  assign w_payload_in = {w_sel_data, w_sel_last, w_grant};

  // Arbitration state: lock on a non-final beat, advance the pointer past the
  // source of each completed packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_rr_ptr   <= '0;
      r_lock_src <= '0;
    end else if (w_accept) begin
      if (r_state == ARB) begin
        if (w_sel_last) begin
          r_rr_ptr <= SRC_W'(rr_next(32'(w_grant), N));
        end else begin
          r_state    <= LOCK;
          r_lock_src <= w_grant;
        end
      end else if (w_sel_last) begin
        r_state  <= ARB;
        r_rr_ptr <= SRC_W'(rr_next(32'(r_lock_src), N));
      end
    end
  end

  pipeline_reg #(
    .Width (PayloadW)
  ) u_out_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_accept),
    .o_ready (w_can_load),
    .i_data  (w_payload_in),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_payload_out)
  );

  assign out_data = w_payload_out[PayloadW-1 -: W];
  assign out_last = w_payload_out[SRC_W];
  assign out_src  = w_payload_out[SRC_W-1:0];

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter with N=4, W=8.
module tb_rr_stream_arbiter;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;
  localparam int unsigned SRC_W = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic [SRC_W-1:0] out_src;

  int checks   = 0;
  int failures = 0;

  rr_stream_arbiter #(
    .W (W),
    .N (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs are applied at the falling edge, outputs sampled there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3, input logic [3:0] l);
    in_valid = v;
    in_data  = {d3, d2, d1, d0};
    in_last  = l;
  endtask

  task automatic chk_ready(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, 32'(in_ready), 32'(exp));
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] s,
                         input logic l);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".src"}, 32'(out_src), 32'(s));
    chk({tag, ".last"}, 32'(out_last), 32'(l));
  endtask

  initial begin
    // Reset with every requester valid.
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(4'hF, 8'h10, 8'h11, 8'h12, 8'h13, 4'hF);
    @(negedge clk);
    chk_ready("rst.in_ready", 4'b0000);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_last", 32'(out_last), 32'd0);
    chk("rst.out_src", 32'(out_src), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all four single-beat requesters, first grant to index 0.
    chk_ready("fair.first_grant", 4'b0001);
    step(); chk_out("fair0", 8'h10, 2'd0, 1'b1);
    chk_ready("fair.grant1", 4'b0010);
    step(); chk_out("fair1", 8'h11, 2'd1, 1'b1);
    step(); chk_out("fair2", 8'h12, 2'd2, 1'b1);
    step(); chk_out("fair3", 8'h13, 2'd3, 1'b1);
    step(); chk_out("fair4", 8'h10, 2'd0, 1'b1);
    // rr_ptr is now 1.
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    step(); chk("fair.drain", 32'(out_valid), 32'd0);

    // Single requester 2, then 2 and 3 together: 3 wins.
    drive(4'b0100, 8'h00, 8'h00, 8'h11, 8'h00, 4'hF);
    chk_ready("single.ready", 4'b0100);
    step(); chk_out("single", 8'h11, 2'd2, 1'b1);
    drive(4'b1100, 8'h00, 8'h00, 8'h22, 8'h33, 4'hF);
    chk_ready("single.next_grant", 4'b1000);
    step(); chk_out("single.r3", 8'h33, 2'd3, 1'b1);
    drive(4'b0100, 8'h00, 8'h00, 8'h22, 8'h00, 4'hF);
    step(); chk_out("single.r2", 8'h22, 2'd2, 1'b1);
    // rr_ptr is now 3; a beat from 0 moves it to 1.
    drive(4'b0001, 8'h01, 8'h00, 8'h00, 8'h00, 4'hF);
    step(); chk_out("lock.pre", 8'h01, 2'd0, 1'b1);

    // Packet lock: requester 1 sends A0..A2 while 0 and 2 stay valid.
    drive(4'b0111, 8'h0F, 8'hA0, 8'h2F, 8'h00, 4'b0101);
    chk_ready("lock.r0", 4'b0010);
    step(); chk_out("lock.a0", 8'hA0, 2'd1, 1'b0);
    drive(4'b0111, 8'h0F, 8'hA1, 8'h2F, 8'h00, 4'b0101);
    chk_ready("lock.r1", 4'b0010);
    step(); chk_out("lock.a1", 8'hA1, 2'd1, 1'b0);
    drive(4'b0111, 8'h0F, 8'hA2, 8'h2F, 8'h00, 4'b0111);
    chk_ready("lock.r2", 4'b0010);
    step(); chk_out("lock.a2", 8'hA2, 2'd1, 1'b1);
    drive(4'b0101, 8'h0F, 8'h00, 8'h2F, 8'h00, 4'b0101);
    chk_ready("lock.after", 4'b0100);
    step(); chk_out("lock.next", 8'h2F, 2'd2, 1'b1);
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    step(); chk("lock.drain", 32'(out_valid), 32'd0);
    // rr_ptr is 3; a beat from 0 moves it to 1.
    drive(4'b0001, 8'h02, 8'h00, 8'h00, 8'h00, 4'hF);
    step(); chk_out("bub.pre", 8'h02, 2'd0, 1'b1);

    // Locked source drops valid for two cycles mid-packet.
    drive(4'b0111, 8'h0F, 8'hB0, 8'h2F, 8'h00, 4'b0101);
    step(); chk_out("bub.b0", 8'hB0, 2'd1, 1'b0);
    drive(4'b0101, 8'h0F, 8'h00, 8'h2F, 8'h00, 4'b0101);
    chk_ready("bub.hold_ready", 4'b0010);
    step(); chk("bub.gap1", 32'(out_valid), 32'd0);
    chk_ready("bub.hold_ready2", 4'b0010);
    step(); chk("bub.gap2", 32'(out_valid), 32'd0);
    drive(4'b0111, 8'h0F, 8'hB1, 8'h2F, 8'h00, 4'b0111);
    step(); chk_out("bub.b1", 8'hB1, 2'd1, 1'b1);
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    step(); chk("bub.drain", 32'(out_valid), 32'd0);

    // Backpressure: rr_ptr is 2, so requester 0 is picked after the circular scan.
    drive(4'b0001, 8'h05, 8'h00, 8'h00, 8'h00, 4'hF);
    step(); chk_out("bp.load", 8'h05, 2'd0, 1'b1);
    out_ready = 1'b0;
    drive(4'b0010, 8'h00, 8'h06, 8'h00, 8'h00, 4'hF);
    for (int i = 0; i < 3; i++) begin
      chk_ready("bp.ready_low", 4'b0000);
      step();
      chk("bp.held_valid", 32'(out_valid), 32'd1);
      chk("bp.held_data", 32'(out_data), 32'h05);
    end
    out_ready = 1'b1;
    chk_ready("bp.release", 4'b0010);
    step(); chk_out("bp.next", 8'h06, 2'd1, 1'b1);
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    step(); chk("bp.drain", 32'(out_valid), 32'd0);

    // Wrap: move rr_ptr to 3 with a beat from 2, then 0 and 3 compete.
    drive(4'b0100, 8'h00, 8'h00, 8'h07, 8'h00, 4'hF);
    step(); chk_out("wrap.pre", 8'h07, 2'd2, 1'b1);
    drive(4'b1001, 8'h40, 8'h00, 8'h00, 8'h43, 4'hF);
    chk_ready("wrap.g3", 4'b1000);
    step(); chk_out("wrap.r3", 8'h43, 2'd3, 1'b1);
    chk_ready("wrap.g0", 4'b0001);
    step(); chk_out("wrap.r0", 8'h40, 2'd0, 1'b1);
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    step();

    // Reset after first beat of a 3-beat packet from requester 3.
    drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'hC0, 4'b0000);
    step(); chk_out("mid.c0", 8'hC0, 2'd3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_valid", 32'(out_valid), 32'd0);
    chk("mid.rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Back in ARB with rr_ptr=0: requester 0 beats the former lock owner 3.
    drive(4'b1001, 8'h50, 8'h00, 8'h00, 8'h53, 4'hF);
    chk_ready("mid.after_rst", 4'b0001);
    step(); chk_out("mid.r0", 8'h50, 2'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
